// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface inst_fetch_unit_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              Mem_req;
  logic [ADDR_W-1:0] Mem_addr;
  logic              Mem_ack;
  logic [DATA_W-1:0] Mem_rdata;

  // Fetch unit drives the request side
  modport master (
    output Mem_req,
    output Mem_addr,
    input  Mem_ack,
    input  Mem_rdata
  );

  // Memory answers with a single-cycle ack carrying the data
  modport slave (
    input  Mem_req,
    input  Mem_addr,
    output Mem_ack,
    output Mem_rdata
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch unit with flush drain, timeout and
// misalignment fault. The fault is sticky until Clr.
module inst_fetch_unit #(
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned ADDR_W  = 32,
  localparam int unsigned DATA_W  = 32,
  localparam int unsigned CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [ADDR_W-1:0] Pc_addr,
  input  logic              Pc_valid,
  output logic              Pc_stall,
  input  logic              Flush,
  inst_fetch_unit_if.master mem,
  output logic [DATA_W-1:0] Inst,
  output logic              Inst_valid,
  input  logic              Inst_ready,
  output logic              Fault
);

  localparam int unsigned CNT_EXT_W = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_HOLD,
    S_ERR
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   inst_q;
  logic [DATA_W-1:0]   inst_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                mem_req_q;
  logic                mem_req_d;
  logic                inst_valid_q;
  logic                inst_valid_d;
  logic                fault_q;
  logic                fault_d;
  logic                fetch_ok;
  logic                accept;
  logic                misalign;
  logic                waiting;
  logic                tmo_hit;

  // Request qualification: a valid, non-flushed PC either starts a fetch or faults
  assign fetch_ok = Pc_valid && !Flush;
  assign accept   = (state_q == S_IDLE) && fetch_ok && (Pc_addr[1:0] == 2'b00);
  assign misalign = (state_q == S_IDLE) && fetch_ok && (Pc_addr[1:0] != 2'b00);
  assign waiting  = ((state_q == S_REQ) || (state_q == S_DRAIN)) && !mem.Mem_ack;
  // This un-acked cycle is the TIMEOUT-th one; an ack in the same cycle wins
  assign tmo_hit  = (CNT_EXT_W'(cnt_q) + CNT_EXT_W'(1)) == CNT_EXT_W'(TIMEOUT);

  // State register
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
        end else if (misalign) begin
          state_d = S_ERR;
        end
      end
      S_REQ: begin
        if (mem.Mem_ack) begin
          state_d = Flush ? S_IDLE : S_HOLD;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else if (Flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem.Mem_ack) begin
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_HOLD: begin
        if (Flush || Inst_ready) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath next values, registered below
  always_comb begin
    Pc_stall     = 1'b1;
    mem_req_d    = 1'b0;
    inst_valid_d = 1'b0;
    fault_d      = 1'b0;
    addr_d       = addr_q;
    inst_d       = inst_q;
    cnt_d        = cnt_q;

    Pc_stall     = Clr || !accept;
    mem_req_d    = (state_d == S_REQ) || (state_d == S_DRAIN);
    inst_valid_d = (state_d == S_HOLD);
    fault_d      = (state_d == S_ERR);

    if (accept) begin
      addr_d = Pc_addr;
      cnt_d  = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if ((state_q == S_REQ) && (state_d == S_HOLD)) begin
      inst_d = mem.Mem_rdata;
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge Clk) begin
    if (Clr) begin
      mem_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      addr_q       <= '0;
      inst_q       <= '0;
      cnt_q        <= '0;
    end else begin
      mem_req_q    <= mem_req_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem.Mem_req  = mem_req_q;
  assign mem.Mem_addr = addr_q;
  assign Inst         = inst_q;
  assign Inst_valid   = inst_valid_q;
  assign Fault        = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed scenarios followed by random traffic, checked against a
// transaction-level model of the fetch unit.
module tb_inst_fetch_unit;
  localparam int unsigned TMO = 4;

  logic        Clk;
  logic        Clr;
  logic [31:0] Pc_addr;
  logic        Pc_valid;
  logic        Pc_stall;
  logic        Flush;
  logic [31:0] Inst;
  logic        Inst_valid;
  logic        Inst_ready;
  logic        Fault;

  inst_fetch_unit_if mem_bus ();

  inst_fetch_unit #(.TIMEOUT(TMO)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .Pc_addr   (Pc_addr),
    .Pc_valid  (Pc_valid),
    .Pc_stall  (Pc_stall),
    .Flush     (Flush),
    .mem       (mem_bus),
    .Inst      (Inst),
    .Inst_valid(Inst_valid),
    .Inst_ready(Inst_ready),
    .Fault     (Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one outstanding fetch, whether its data will be thrown away,
  // a held instruction, the sticky fault, and un-acked cycles so far.
  bit          m_out;
  bit          m_discard;
  bit          m_hold;
  bit          m_fault;
  int unsigned m_wait;
  logic [31:0] m_addr;
  logic [31:0] m_inst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_discard = 0; m_hold = 0; m_fault = 0;
    m_wait = 0; m_addr = '0; m_inst = '0;
  endtask

  function automatic bit model_idle();
    return !m_out && !m_hold && !m_fault;
  endfunction

  task automatic model_step(input logic clr, input logic [31:0] addr, input logic valid,
                            input logic flush, input logic ack, input logic [31:0] rdata,
                            input logic ready);
    if (clr) begin
      model_reset();
    end else if (m_fault) begin
      // stuck until reset
    end else if (m_hold) begin
      if (flush || ready) m_hold = 0;
    end else if (m_out) begin
      if (ack) begin
        if (!m_discard && !flush) begin
          m_inst = rdata;
          m_hold = 1;
        end
        m_out = 0;
        m_discard = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_fault = 1;
          m_out = 0;
          m_discard = 0;
        end else if (flush) begin
          m_discard = 1;
        end
      end
    end else if (valid && !flush) begin
      if (addr % 4 == 0) begin
        m_addr = addr;
        m_out = 1;
        m_wait = 0;
      end else begin
        m_fault = 1;
      end
    end
  endtask

  // One clock: compare registered outputs, apply inputs, compare the stall, advance the model
  task automatic cycle(input logic clr, input logic [31:0] addr, input logic valid,
                       input logic flush, input logic ack, input logic [31:0] rdata,
                       input logic ready);
    logic exp_stall;
    @(negedge Clk);
    check("mem_req",    mem_bus.Mem_req,  m_out);
    check("mem_addr",   mem_bus.Mem_addr, m_addr);
    check("inst_valid", Inst_valid,       m_hold);
    check("inst",       Inst,             m_inst);
    check("fault",      Fault,            m_fault);
    Clr = clr; Pc_addr = addr; Pc_valid = valid; Flush = flush;
    mem_bus.Mem_ack = ack; mem_bus.Mem_rdata = rdata; Inst_ready = ready;
    exp_stall = clr || !(model_idle() && valid && !flush && (addr % 4 == 0));
    #1;
    check("pc_stall", Pc_stall, exp_stall);
    @(posedge Clk);
    model_step(clr, addr, valid, flush, ack, rdata, ready);
  endtask

  task automatic idle_cycle();
    cycle(0, 32'h0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    Clr = 1; Pc_addr = '0; Pc_valid = 0; Flush = 0; Inst_ready = 0;
    mem_bus.Mem_ack = 0; mem_bus.Mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_mem_req",    mem_bus.Mem_req,  0);
    check("rst_mem_addr",   mem_bus.Mem_addr, 0);
    check("rst_inst",       Inst,             0);
    check("rst_inst_valid", Inst_valid,       0);
    check("rst_fault",      Fault,            0);
    check("rst_pc_stall",   Pc_stall,         1);

    // Basic fetch
    cycle(0, 32'h4, 1, 0, 0, 32'h0, 0);
    #1 check("basic_req", mem_bus.Mem_req, 1);
    check("basic_addr", mem_bus.Mem_addr, 32'h4);
    cycle(0, 32'h0, 0, 0, 1, 32'h2008_0005, 0);
    #1 check("basic_valid", Inst_valid, 1);
    check("basic_inst", Inst, 32'h2008_0005);
    cycle(0, 32'h0, 0, 0, 0, 32'h0, 1);
    #1 check("basic_release", Inst_valid, 0);

    // Backpressure
    cycle(0, 32'h8, 1, 0, 0, 32'h0, 0);
    cycle(0, 32'h0, 0, 0, 1, 32'hCAFE_0001, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 32'hC, 1, 0, 0, 32'h0, 0);
      #1 check("bp_hold_valid", Inst_valid, 1);
      check("bp_hold_inst", Inst, 32'hCAFE_0001);
    end
    cycle(0, 32'h0, 0, 0, 0, 32'h0, 1);
    #1 check("bp_release", Inst_valid, 0);

    // Flush mid-request; the ack lands on the cycle the counter would time out
    cycle(0, 32'h10, 1, 0, 0, 32'h0, 0);
    idle_cycle();
    cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
    #1 check("flush_req_held", mem_bus.Mem_req, 1);
    idle_cycle();
    cycle(0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    #1 check("flush_req_drop", mem_bus.Mem_req, 0);
    check("flush_no_valid", Inst_valid, 0);
    check("flush_no_fault", Fault, 0);

    // Timeout
    cycle(0, 32'h20, 1, 0, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++) idle_cycle();
    #1 check("tmo_not_yet", Fault, 0);
    idle_cycle();
    #1 check("tmo_fault", Fault, 1);
    check("tmo_req_off", mem_bus.Mem_req, 0);
    cycle(0, 32'h40, 1, 0, 1, 32'h1234_5678, 1);
    #1 check("tmo_sticky", Fault, 1);
    cycle(1, 32'h0, 0, 0, 0, 32'h0, 0);
    #1 check("tmo_cleared", Fault, 0);

    // Misaligned address
    cycle(0, 32'h6, 1, 0, 0, 32'h0, 0);
    #1 check("mis_no_req", mem_bus.Mem_req, 0);
    check("mis_fault", Fault, 1);
    cycle(0, 32'h8, 1, 0, 0, 32'h0, 0);
    cycle(1, 32'h0, 0, 0, 0, 32'h0, 0);

    // Reset mid-request, late ack ignored
    cycle(0, 32'h40, 1, 0, 0, 32'h0, 0);
    cycle(1, 32'h0, 0, 0, 0, 32'h0, 0);
    #1 check("rmr_req", mem_bus.Mem_req, 0);
    check("rmr_addr", mem_bus.Mem_addr, 0);
    check("rmr_inst", Inst, 0);
    cycle(0, 32'h0, 0, 0, 1, 32'h5555_AAAA, 1);
    #1 check("rmr_ack_ignored", Inst_valid, 0);
    check("rmr_inst_kept", Inst, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic        c, v, f, k, r;
      logic [31:0] d;
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      c = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 60);
      f = ($urandom_range(0, 99) < 10);
      k = m_out ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 99) < 50);
      d = $urandom;
      cycle(c, a, v, f, k, d, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of cycles a memory request may remain un-acknowledged before a fault (legal range 1..65535).
REQ-002 Clk  in  1  rising-edge clock; all state changes on rising edge of Clk.
REQ-003 Clr  in  1  reset, synchronous and active-high.
REQ-004 Pc_addr  in  32  fetch address driven by the PC register.
REQ-005 Pc_valid  in  1  Pc_addr is a valid fetch address this cycle.
REQ-006 Pc_stall  out  1  high means the PC register shall hold its value.
REQ-007 Flush  in  1  redirect; discard any pending or held fetch.
REQ-008 Mem_req  out  1  instruction memory request.
REQ-009 Mem_addr  out  32  request address, word-aligned.
REQ-010 Mem_ack  in  1  single-cycle pulse; Mem_rdata is valid in the same cycle.
REQ-011 Mem_rdata  in  32  instruction word from memory.
REQ-012 Inst  out  32  fetched instruction.
REQ-013 Inst_valid  out  1  Inst holds a valid instruction.
REQ-014 Inst_ready  in  1  downstream accepts Inst this cycle.
REQ-015 Fault  out  1  sticky error flag, either misaligned address or timeout.

Function
REQ-016 FSM states: IDLE, REQ, DRAIN, HOLD, ERR. Exactly one state is active per cycle.
REQ-017 IDLE behaviour:
 - Accept condition: Pc_valid=1, Flush=0, Pc_addr[1:0]=00.
 - On accept: latch Pc_addr into Mem_addr and enter REQ.
 - If Pc_valid=1, Flush=0 and Pc_addr[1:0]!=00: enter ERR and issue no request.
 - Otherwise: stay in IDLE.
REQ-018 Pc_stall is combinational and equals NOT(state==IDLE AND accept condition). It is 1 in every other state and in every other IDLE cycle.
REQ-019 Mem_req is 1 in REQ and DRAIN and 0 otherwise. Mem_addr holds stable from the accept cycle until the next accept.
REQ-020 REQ, Mem_ack=1, Flush=0: capture Mem_rdata into Inst and enter HOLD.
REQ-021 REQ, Mem_ack=1, Flush=1: discard the data and enter IDLE.
REQ-022 REQ, Mem_ack=0, Flush=1: enter DRAIN. The request stays asserted until its ack arrives.
REQ-023 DRAIN, Mem_ack=1: discard Mem_rdata and enter IDLE. Flush in DRAIN has no further effect.
REQ-024 Timeout counter (16 bits):
 - Clears on entry to REQ.
 - Increments each REQ/DRAIN cycle without Mem_ack.
 - When it reaches TIMEOUT with Mem_ack=0, enter ERR.
 - Mem_ack arriving in the same cycle the counter reaches TIMEOUT wins; no fault.
REQ-025 HOLD: Inst_valid=1 and Inst is stable.
 - Flush=1: enter IDLE with Inst_valid 0 next cycle. Flush has priority over Inst_ready.
 - Inst_ready=1, Flush=0: enter IDLE with Inst_valid 0 next cycle.
 - Otherwise: stay in HOLD.
REQ-026 Inst_valid is 1 only in HOLD. Inst retains its last value outside HOLD.
REQ-027 ERR: Fault=1, Mem_req=0, Pc_stall=1. Flush, Pc_valid and Mem_ack are ignored. Only Clr exits ERR.
REQ-028 Latency: address accepted in cycle N gives Mem_req=1 in cycle N+1. Mem_ack in cycle M gives Inst_valid=1 in cycle M+1. Minimum accept-to-Inst_valid latency is 2 cycles.
REQ-029 At most one request is outstanding. No new address is accepted before the current request is acked or the block is in ERR.

Reset
REQ-030 Clr=1 at a rising edge forces, in the next cycle:
 - state IDLE;
 - Mem_req=0, Mem_addr=0;
 - Inst=0, Inst_valid=0;
 - Fault=0;
 - timeout counter 0.
REQ-031 While Clr=1, Pc_stall=1 and Pc_valid is ignored.
REQ-032 Clr has priority over every other input in every state, including mid-request and ERR. A Mem_ack arriving after a reset that aborted a request is ignored in IDLE.

Verification
REQ-033 Basic fetch:
 - Stimulus: Pc_addr=0x00000004, Pc_valid=1 in cycle 0; Mem_ack with Mem_rdata=0x20080005 in cycle 1; Inst_ready=1 from cycle 2.
 - Response: Pc_stall=0 in cycle 0; Mem_req=1 and Mem_addr=0x00000004 in cycle 1; Inst_valid=1 and Inst=0x20080005 in cycle 2; Inst_valid=0 in cycle 3.
REQ-034 Backpressure:
 - Stimulus: as REQ-033, but Inst_ready=0 for 3 cycles.
 - Response: Inst_valid and Inst are held for 3 cycles and Pc_stall=1 throughout; release happens the cycle after Inst_ready=1.
REQ-035 Flush mid-request:
 - Stimulus: Flush=1 one cycle after Mem_req rises; Mem_ack 3 cycles later.
 - Response: state goes to DRAIN; Mem_req is held until the ack; Inst_valid never rises; IDLE follows the ack cycle.
REQ-036 Timeout:
 - Stimulus: TIMEOUT=4; Mem_ack is never asserted.
 - Response: Fault=1 after 4 un-acked REQ cycles; Mem_req=0; Fault stays set until Clr=1 clears it.
REQ-037 Misaligned address:
 - Stimulus: Pc_addr=0x00000006, Pc_valid=1.
 - Response: no Mem_req; Fault=1 the next cycle; Pc_stall=1 until Clr.
REQ-038 Reset mid-request:
 - Stimulus: Clr=1 while in REQ, then Mem_ack in the following cycle.
 - Response: all outputs at REQ-030 values; the ack is ignored; Inst_valid stays 0.
